// File: rtl/effect_crossfade.sv
// Click-free dry/wet crossfader: debounced effect button drives a linear gain ramp
// of 2^FADE_LOG2 sample strobes; two-stage multiply/sum pipeline produces the mix.
module effect_crossfade #(
    parameter int FADE_LOG2       = 8,
    parameter int DEBOUNCE_CYCLES = 700000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_strobe,
    input  logic [15:0] dry_in,
    input  logic [15:0] wet_in,
    input  logic        effect_button_n,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        effect_active,
    output logic        fade_busy
);

    localparam int GW = FADE_LOG2 + 1;
    localparam int PW = 16 + FADE_LOG2 + 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [GW-1:0] G_MAX   = GW'(1 << FADE_LOG2);
    localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {DRY, FADE_UP, WET, FADE_DOWN} state_t;

    logic          btn_s1_q, btn_s2_q;
    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level;

    state_t        state_q;
    logic [GW-1:0] g_q;

    logic [PW-1:0] p_dry_q, p_wet_q;
    logic [PW-1:0] sum;
    logic [1:0]    vld_pipe_q;
    logic [15:0]   sample_q;

    // Button goes through two flops before anyone looks at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q <= 1'b1;
            btn_s2_q <= 1'b1;
        end else begin
            btn_s1_q <= effect_button_n;
            btn_s2_q <= btn_s1_q;
        end
    end

    assign level = ~btn_s2_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = '0;
        if (level != active_q) begin
            if (cnt_q == CNT_END) begin
                active_d = level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // Gain only moves on a strobe, one step at a time, so reversals never jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRY;
            g_q     <= '0;
        end else if (sample_strobe) begin
            case (state_q)
                DRY: begin
                    if (active_q) begin
                        state_q <= FADE_UP;
                        g_q     <= g_q + 1'b1;
                    end
                end
                FADE_UP: begin
                    if (active_q) begin
                        g_q <= g_q + 1'b1;
                        if (g_q + 1'b1 == G_MAX) state_q <= WET;
                    end else begin
                        g_q     <= g_q - 1'b1;
                        state_q <= (g_q == GW'(1)) ? DRY : FADE_DOWN;
                    end
                end
                WET: begin
                    if (!active_q) begin
                        state_q <= FADE_DOWN;
                        g_q     <= g_q - 1'b1;
                    end
                end
                FADE_DOWN: begin
                    if (!active_q) begin
                        g_q <= g_q - 1'b1;
                        if (g_q == GW'(1)) state_q <= DRY;
                    end else begin
                        g_q     <= g_q + 1'b1;
                        state_q <= (g_q + 1'b1 == G_MAX) ? WET : FADE_UP;
                    end
                end
                default: begin
                    state_q <= DRY;
                    g_q     <= '0;
                end
            endcase
        end
    end

    // Stage 1 weights with the pre-update gain; stage 2 sums and drops the fraction.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_dry_q    <= '0;
            p_wet_q    <= '0;
            vld_pipe_q <= '0;
            sample_q   <= 16'h8000;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], sample_strobe};
            if (sample_strobe) begin
                p_dry_q <= PW'(dry_in) * PW'(G_MAX - g_q);
                p_wet_q <= PW'(wet_in) * PW'(g_q);
            end
            if (vld_pipe_q[0]) begin
                sample_q <= sum[FADE_LOG2 +: 16];
            end
        end
    end

    assign sum = p_dry_q + p_wet_q;

    logic unused_sum_bits;
    assign unused_sum_bits = ^{sum[PW-1], sum[FADE_LOG2-1:0]};

    assign sample_out    = sample_q;
    assign sample_valid  = vld_pipe_q[1];
    assign effect_active = active_q;
    assign fade_busy     = (state_q == FADE_UP) || (state_q == FADE_DOWN);

endmodule
